dac_xy: RTL and testbench
=========================

# dac_xy

Transmit-side counterpart to the ADC XY capture path. It accepts X/Y deflection samples with RGB enable bits from FPGA logic over a valid/ready stream and buffers them in a small FIFO. It drives them onto the parallel DAC pins at a fixed divided sample rate, generating the DAC sample clock. It sits between vector/pattern generation logic and the board's X/Y DAC and colour outputs.

## Interface
- DATA_BITS, 10, width of X and Y samples
- CLK_DIV, 4, system clocks per DAC sample; even, ≥2
- FIFO_DEPTH, 4, sample buffer entries; power of two, ≥2

- clk  input  1  system clock; all logic in this domain
- reset  input  1  asynchronous, active-high reset
- enable  input  1  run DAC sample timing; low holds the divider
- s_valid  input  1  input sample valid
- s_ready  output  1  FIFO can accept a sample
- s_x  input  DATA_BITS  X sample
- s_y  input  DATA_BITS  Y sample
- s_red, s_grn, s_blu  input  1 each  colour enables
- dac_clk  output  1  DAC sample clock; DAC latches on rising edge
- dac_x, dac_y  output  DATA_BITS  registered DAC data
- dac_red, dac_grn, dac_blu  output  1 each  registered colour outputs
- underflow  output  1  one-cycle pulse: sample slot found FIFO empty
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- FIFO: FIFO_DEPTH × (2·DATA_BITS+3) bits, wrapping read/write pointers, occupancy counter. Push when s_valid && s_ready. s_ready = (level != FIFO_DEPTH), combinational from registered level; no full-bypass.
- Divider: cnt counts 0..CLK_DIV-1 while enable=1 and wraps to 0. When enable=0, cnt is forced to 0 on the next edge and no pops occur.
- dac_clk is registered. It is 1 when cnt ≥ CLK_DIV/2, else 0, giving a 50% duty cycle. It is low whenever enable=0.
- Load cycle: enable=1 and cnt==CLK_DIV-1. On that edge:
  - FIFO non-empty: pop the head into dac_x/dac_y/dac_red/dac_grn/dac_blu.
  - FIFO empty: hold dac_x/dac_y, force all colour outputs to 0 (blank beam), and pulse underflow for one cycle.
- A sample is poppable only if it was pushed in an earlier cycle. A push in the load cycle into an empty FIFO does not prevent underflow.
- A push and pop in the same cycle leaves level unchanged. Pointers update independently.
- Deasserting enable mid-period stops at the current values. Outputs hold, FIFO contents are retained, and the next period after re-enable starts at cnt=0.

## Timing
- Reset values: cnt=0, FIFO empty, level=0, s_ready=1, dac_clk=0, dac_x=dac_y=0, colours 0, underflow=0.
- Data outputs change only on the load edge, when dac_clk goes low at cnt wrap to 0. They are stable for CLK_DIV/2 cycles before the rising dac_clk edge and CLK_DIV/2 cycles after it.
- Input-to-pin latency: from push at edge t, the sample reaches the pins at the first load edge strictly after t, provided the FIFO ahead of it is drained.
- Sustained throughput is 1 sample per CLK_DIV cycles. Back-pressure occurs only when level==FIFO_DEPTH.
- Reset assertion at any point clears immediately and asynchronously. In-flight FIFO data is discarded.

## Test plan
- Reset/idle: assert reset mid-stream with 3 entries queued -> level=0, s_ready=1, all dac outputs 0, dac_clk=0 immediately. After release with no input, underflow pulses once every 4 cycles.
- Stream: CLK_DIV=4, push X=0x001..0x008, Y=0x3FF-X, red=1 back-to-back -> s_ready drops at level 4. Pins present each sample in order for exactly 4 cycles. dac_clk pattern is 0,0,1,1. No underflow until the FIFO drains.
- Underflow/blank: push one sample X=0x155, Y=0x2AA, rgb=111, then stop -> next period outputs rgb=000 with X/Y held at 0x155/0x2AA, and underflow pulses once per period.
- Push in load cycle into empty FIFO: sample X=0x07F pushed when cnt==3 -> underflow that period. 0x07F appears at the following load edge.
- Enable gating: drop enable at cnt=2 with 2 entries queued -> dac_clk=0, cnt=0, outputs and level frozen. On re-enable, the first pop occurs 4 cycles later.
- Full boundary: hold s_valid=1 continuously -> simultaneous push and pop at level 4 never occurs, since s_ready=0. level oscillates between 3 and 4, and no sample is lost or duplicated (scoreboard check).

Source files
------------

// File: rtl/dac_xy_if.sv
// Sample stream from pattern logic into the XY DAC driver.
// master drives valid/x/y/rgb and reads ready; slave the reverse.
interface dac_xy_if #(
    parameter int DATA_BITS = 10
) ();
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_BITS-1:0] s_x;
    logic [DATA_BITS-1:0] s_y;
    logic                 s_red;
    logic                 s_grn;
    logic                 s_blu;

    modport master (
        output s_valid, s_x, s_y, s_red, s_grn, s_blu,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_x, s_y, s_red, s_grn, s_blu,
        output s_ready
    );
endinterface

// File: rtl/dac_xy.sv
// XY DAC driver: buffers X/Y/RGB samples and plays them out at clk/CLK_DIV.
// Ports: clk, reset (async high), enable, s (stream slave),
// dac_clk/dac_x/dac_y/dac_red/dac_grn/dac_blu pins, underflow, level.
module dac_xy #(
    parameter int DATA_BITS  = 10,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    dac_xy_if.slave                       s,
    output logic                          dac_clk,
    output logic [DATA_BITS-1:0]          dac_x,
    output logic [DATA_BITS-1:0]          dac_y,
    output logic                          dac_red,
    output logic                          dac_grn,
    output logic                          dac_blu,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = 2 * DATA_BITS + 3;

    logic [SW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [CW-1:0] r_cnt;
    logic          r_dac_clk;
    logic [DATA_BITS-1:0] r_dac_x;
    logic [DATA_BITS-1:0] r_dac_y;
    logic [2:0]    r_rgb;
    logic          r_underflow;

    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic          w_empty;
    logic [CW-1:0] w_cnt_nxt;
    logic [SW-1:0] w_wdata;
    logic [SW-1:0] w_head;

    assign s.s_ready = (r_level != LW'(FIFO_DEPTH));
    assign w_push    = s.s_valid && s.s_ready;
    assign w_empty   = (r_level == '0);
    assign w_load    = enable && (r_cnt == CW'(CLK_DIV - 1));
    // level is the registered count, so a same-cycle push is not poppable
    assign w_pop     = w_load && !w_empty;
    assign w_wdata   = {s.s_x, s.s_y, s.s_red, s.s_grn, s.s_blu};
    assign w_head    = r_mem[r_rptr];

    always_comb begin
        w_cnt_nxt = '0;
        if (enable && !w_load)
            w_cnt_nxt = r_cnt + 1'b1;
    end

    // Storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_dac_clk   <= 1'b0;
            r_dac_x     <= '0;
            r_dac_y     <= '0;
            r_rgb       <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            // dac_clk tracks the next count so it is high for the second half
            r_dac_clk   <= (w_cnt_nxt >= CW'(CLK_DIV / 2));
            r_underflow <= w_load && w_empty;
            if (w_pop) begin
                r_dac_x <= w_head[SW-1 -: DATA_BITS];
                r_dac_y <= w_head[3 +: DATA_BITS];
                r_rgb   <= w_head[2:0];
            end else if (w_load) begin
                // starved slot: hold position, blank the beam
                r_rgb   <= '0;
            end
        end
    end

    assign dac_clk   = r_dac_clk;
    assign dac_x     = r_dac_x;
    assign dac_y     = r_dac_y;
    assign dac_red   = r_rgb[2];
    assign dac_grn   = r_rgb[1];
    assign dac_blu   = r_rgb[0];
    assign underflow = r_underflow;
    assign level     = r_level;
endmodule

// File: tb/tb_dac_xy.sv
// Testbench for dac_xy: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_dac_xy;
    localparam int DB  = 10;
    localparam int DIV = 4;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          dac_clk;
    logic [DB-1:0] dac_x;
    logic [DB-1:0] dac_y;
    logic          dac_red;
    logic          dac_grn;
    logic          dac_blu;
    logic          underflow;
    logic [2:0]    level;

    dac_xy_if #(.DATA_BITS(DB)) bus ();

    dac_xy #(
        .DATA_BITS (DB),
        .CLK_DIV   (DIV),
        .FIFO_DEPTH(DEP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .s        (bus),
        .dac_clk  (dac_clk),
        .dac_x    (dac_x),
        .dac_y    (dac_y),
        .dac_red  (dac_red),
        .dac_grn  (dac_grn),
        .dac_blu  (dac_blu),
        .underflow(underflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of samples plus the position within the
    // current sample period; one slot per DIV enabled cycles.
    typedef logic [2*DB+2:0] smp_t;
    smp_t          q[$];
    int            ph;
    logic [DB-1:0] m_x, m_y;
    logic [2:0]    m_rgb;
    logic          m_uf;
    int            m_pre;
    bit            m_push;
    smp_t          m_h;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            ph = 0; m_x = '0; m_y = '0; m_rgb = '0; m_uf = 1'b0;
        end else begin
            m_pre  = q.size();
            m_push = bus.s_valid && (m_pre < DEP);
            m_uf   = 1'b0;
            if (!enable) begin
                ph = 0;
            end else begin
                if (ph == DIV - 1) begin
                    if (m_pre > 0) begin
                        m_h   = q.pop_front();
                        m_x   = m_h[2*DB+2 -: DB];
                        m_y   = m_h[DB+2 -: DB];
                        m_rgb = m_h[2:0];
                    end else begin
                        m_rgb = '0;
                        m_uf  = 1'b1;
                    end
                end
                ph = (ph + 1) % DIV;
            end
            if (m_push)
                q.push_back({bus.s_x, bus.s_y, bus.s_red, bus.s_grn, bus.s_blu});
        end
    end

    task automatic check_all();
        cmp("level", 32'(level), 32'(q.size()));
        cmp("s_ready", 32'(bus.s_ready), 32'(q.size() < DEP));
        cmp("dac_clk", 32'(dac_clk), 32'(ph >= DIV / 2));
        cmp("dac_x", 32'(dac_x), 32'(m_x));
        cmp("dac_y", 32'(dac_y), 32'(m_y));
        cmp("rgb", 32'({dac_red, dac_grn, dac_blu}), 32'(m_rgb));
        cmp("underflow", 32'(underflow), 32'(m_uf));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit v, input logic [DB-1:0] x,
                         input logic [DB-1:0] y, input logic [2:0] rgb);
        bus.s_valid = v;
        bus.s_x     = x;
        bus.s_y     = y;
        {bus.s_red, bus.s_grn, bus.s_blu} = rgb;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit            en;
        bit            vld;
        logic [DB-1:0] x;
        int            lvl;
        bit            rdy;
        bit            dclk;
        logic [DB-1:0] dx;
        bit            red;
        bit            uf;
    } vec_t;

    vec_t tv[8];
    int   cnt;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0] = '{1, 1, 10'd1, 1, 1, 0, 10'd0, 0, 0};
        tv[1] = '{1, 1, 10'd2, 2, 1, 1, 10'd0, 0, 0};
        tv[2] = '{1, 1, 10'd3, 3, 1, 1, 10'd0, 0, 0};
        tv[3] = '{1, 1, 10'd4, 3, 1, 0, 10'd1, 1, 0};
        tv[4] = '{1, 1, 10'd5, 4, 0, 0, 10'd1, 1, 0};
        tv[5] = '{1, 1, 10'd6, 4, 0, 1, 10'd1, 1, 0};
        tv[6] = '{1, 0, 10'd0, 4, 0, 1, 10'd1, 1, 0};
        tv[7] = '{1, 0, 10'd0, 3, 1, 0, 10'd2, 1, 0};

        reset  = 1'b1;
        enable = 1'b0;
        drive(0, '0, '0, '0);
        @(negedge clk);
        cmp("rst_level", 32'(level), 0);
        cmp("rst_ready", 32'(bus.s_ready), 1);
        cmp("rst_dclk", 32'(dac_clk), 0);
        cmp("rst_x", 32'(dac_x), 0);
        cmp("rst_uf", 32'(underflow), 0);
        check_all();
        reset = 1'b0;

        // vector table: back-to-back stream into an empty FIFO
        foreach (tv[i]) begin
            enable = tv[i].en;
            drive(tv[i].vld, tv[i].x, 10'h3FF - tv[i].x, 3'b100);
            step();
            cmp("tv_level", 32'(level), 32'(tv[i].lvl));
            cmp("tv_ready", 32'(bus.s_ready), 32'(tv[i].rdy));
            cmp("tv_dclk", 32'(dac_clk), 32'(tv[i].dclk));
            cmp("tv_x", 32'(dac_x), 32'(tv[i].dx));
            cmp("tv_red", 32'(dac_red), 32'(tv[i].red));
            cmp("tv_uf", 32'(underflow), 32'(tv[i].uf));
        end

        // asynchronous reset mid-cycle with 3 entries queued
        drive(0, '0, '0, '0);
        #2 reset = 1'b1;
        #1;
        cmp("arst_level", 32'(level), 0);
        cmp("arst_ready", 32'(bus.s_ready), 1);
        cmp("arst_x", 32'(dac_x), 0);
        cmp("arst_y", 32'(dac_y), 0);
        cmp("arst_rgb", 32'({dac_red, dac_grn, dac_blu}), 0);
        cmp("arst_dclk", 32'(dac_clk), 0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (underflow) cnt++;
        end
        cmp("idle_uf_pulses", 32'(cnt), 4);

        // single sample then starvation: blanked, position held
        do_reset();
        enable = 1'b1;
        drive(1, 10'h155, 10'h2AA, 3'b111);
        step();
        drive(0, '0, '0, '0);
        for (int i = 0; i < 3; i++) step();
        cmp("blank_shown_rgb", 32'({dac_red, dac_grn, dac_blu}), 3'b111);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (underflow) cnt++;
        end
        cmp("blank_x", 32'(dac_x), 10'h155);
        cmp("blank_y", 32'(dac_y), 10'h2AA);
        cmp("blank_rgb", 32'({dac_red, dac_grn, dac_blu}), 0);
        cmp("blank_uf_pulses", 32'(cnt), 2);

        // push during the load cycle into an empty FIFO
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 8 && ph != DIV - 1; i++) step();
        drive(1, 10'h07F, 10'h380, 3'b010);
        step();
        cmp("ldpush_uf", 32'(underflow), 1);
        cmp("ldpush_level", 32'(level), 1);
        drive(0, '0, '0, '0);
        for (int i = 0; i < 4; i++) step();
        cmp("ldpush_x", 32'(dac_x), 10'h07F);
        cmp("ldpush_uf2", 32'(underflow), 0);

        // enable gating with two queued entries
        do_reset();
        enable = 1'b1;
        drive(1, 10'h0A0, 10'h0B0, 3'b001);
        step();
        drive(1, 10'h0A1, 10'h0B1, 3'b011);
        step();
        drive(0, '0, '0, '0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            cmp("gate_dclk", 32'(dac_clk), 0);
            cmp("gate_level", 32'(level), 2);
            cmp("gate_x", 32'(dac_x), 0);
        end
        enable = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10 && level == 3'd2; i++) begin
            step();
            cnt++;
        end
        cmp("gate_first_pop", 32'(cnt), 4);
        cmp("gate_pop_x", 32'(dac_x), 10'h0A0);

        // continuous valid: level must settle between 3 and 4
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1, DB'($urandom), DB'($urandom), 3'($urandom));
            step();
            if (i >= 8)
                cmp("full_level_range", 32'(level == 3'd3 || level == 3'd4), 1);
        end

        // randomized traffic with enable toggling
        for (int i = 0; i < 800; i++) begin
            enable = ($urandom_range(0, 15) != 0);
            drive($urandom_range(0, 3) != 0, DB'($urandom), DB'($urandom),
                  3'($urandom));
            step();
        end
        drive(0, '0, '0, '0);
        enable = 1'b1;
        for (int i = 0; i < 24; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
